fgp_fb_writer: RTL

Framebuffer write stage directly downstream of the FGP receive parser. It consumes the parser's offset strobe, payload byte stream and done strobe, and unpacks each 768-byte payload into 512 12-bit pixels (two pixels per three bytes). It writes those pixels into the framebuffer RAM at `offset*512 + pixel_index`. It is the only writer of the framebuffer on the network path.

---
 rtl/fgp_fb_writer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fgp_fb_writer.sv
// Framebuffer write stage: unpacks FGP payload bytes into 12-bit pixels and writes them at offset*PIXELS_PER_PACKET + index.
// Optional offset bounds checking with a DROP state is enabled by defining FGP_FB_BOUNDS_CHECK_EN.
module fgp_fb_writer #(
    parameter int ADDR_WIDTH        = 17,
    parameter int PIXELS_PER_PACKET = 512,
    parameter int MAX_OFFSET        = 149
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  offset_inclk,
    input  logic [7:0]            offset_in,
    input  logic                  inclk,
    input  logic [7:0]            in,
    input  logic                  done_in,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [11:0]           ram_data,
    output logic                  pkt_done,
    output logic                  err,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    localparam int SHIFT  = $clog2(PIXELS_PER_PACKET);
    localparam int IDX_W  = SHIFT + 1;
    localparam int BASE_W = 8 + SHIFT;

`ifdef FGP_FB_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] base;
    logic [IDX_W-1:0]      idx;
    logic [1:0]            phase;
    logic [7:0]            hi;
    logic [3:0]            lo;
    logic                  ovf_seen;
    logic                  we_q;
    logic                  pd_q;

    logic [BASE_W-1:0]     base_full;
    logic                  idx_full;
    logic                  offset_bad;
    logic [ADDR_WIDTH-1:0] pix_addr;

    assign base_full  = BASE_W'(offset_in) << SHIFT;
    assign idx_full   = (idx == IDX_W'(PIXELS_PER_PACKET));
    assign offset_bad = ({24'd0, offset_in} > 32'(MAX_OFFSET));
    assign pix_addr   = base + ADDR_WIDTH'(idx);

    // A write registered from the previous byte is masked while rst is high,
    // so a reset mid-packet never lets that pixel reach the framebuffer.
    assign ram_we    = we_q & ~rst;
    assign pkt_done  = pd_q & ~rst;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            base     <= '0;
            idx      <= '0;
            phase    <= 2'd0;
            hi       <= 8'd0;
            lo       <= 4'd0;
            ovf_seen <= 1'b0;
            we_q     <= 1'b0;
            pd_q     <= 1'b0;
            ram_addr <= '0;
            ram_data <= 12'd0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            pd_q <= 1'b0;
            err  <= 1'b0;
            // The offset strobe wins over any byte arriving in the same cycle.
            if (offset_inclk) begin
                base     <= ADDR_WIDTH'(base_full);
                idx      <= '0;
                phase    <= 2'd0;
                ovf_seen <= 1'b0;
                busy     <= 1'b1;
                if (BOUNDS_EN && offset_bad) begin
                    state <= S_DROP;
                    err   <= 1'b1;
                end else begin
                    state <= S_RECV;
                end
            end else if (inclk) begin
                case (state)
                    S_RECV: begin
                        if (idx_full) begin
                            ovf_seen <= 1'b1;
                            err      <= ~ovf_seen;
                            if (done_in) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            case (phase)
                                2'd0: begin
                                    hi    <= in;
                                    phase <= 2'd1;
                                end
                                2'd1: begin
                                    ram_data <= {hi, in[7:4]};
                                    ram_addr <= pix_addr;
                                    we_q     <= 1'b1;
                                    idx      <= idx + 1'b1;
                                    lo       <= in[3:0];
                                    phase    <= 2'd2;
                                end
                                default: begin
                                    ram_data <= {lo, in};
                                    ram_addr <= pix_addr;
                                    we_q     <= 1'b1;
                                    idx      <= idx + 1'b1;
                                    phase    <= 2'd0;
                                end
                            endcase
                            // Only a done on a pixel boundary completes the packet cleanly.
                            if (done_in) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                if (phase == 2'd2) pd_q <= 1'b1;
                                else               err  <= 1'b1;
                            end
                        end
                    end
                    S_DROP: begin
                        if (done_in) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
